// File: rtl/exec_writeback_stage_if.sv
// rtl/exec_writeback_stage_if.sv - handshake bundle between ALU, writeback stage and register file
// master drives the ALU op stream and consumes writeback entries; slave is the stage itself.
interface exec_writeback_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [3:0]  in_flags;
   logic        in_setflags;
   logic [2:0]  in_dest;
   logic [2:0]  in_cond;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_dest;
   logic        out_taken;

   modport master (
      output in_valid, in_result, in_flags, in_setflags, in_dest, in_cond, out_ready,
      input  in_ready, out_valid, out_result, out_dest, out_taken
   );

   modport slave (
      input  in_valid, in_result, in_flags, in_setflags, in_dest, in_cond, out_ready,
      output in_ready, out_valid, out_result, out_dest, out_taken
   );
endinterface

// File: rtl/exec_writeback_stage.sv
// rtl/exec_writeback_stage.sv - ALU writeback register with architectural flags and branch condition
// EXEC_SKID_BUFFER_EN adds a skid entry so in_ready is a flop output instead of a path from out_ready.
module exec_writeback_stage (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flags_clr,
   output logic [3:0]              flags_q,
   exec_writeback_stage_if.slave   bus
);

   logic       accept;
   logic [3:0] eff_flags;
   logic       in_taken;

   assign accept = bus.in_valid & bus.in_ready;

   // Condition is evaluated against the flags this op itself produces, if it sets them.
   always_comb begin
      eff_flags = bus.in_setflags ? bus.in_flags : flags_q;
      in_taken  = 1'b0;
      case (bus.in_cond)
         3'b000:  in_taken = 1'b1;
         3'b001:  in_taken = eff_flags[3];
         3'b010:  in_taken = ~eff_flags[3];
         3'b011:  in_taken = eff_flags[2];
         3'b100:  in_taken = eff_flags[1];
         3'b101:  in_taken = ~eff_flags[1];
         3'b110:  in_taken = eff_flags[0];
         default: in_taken = 1'b0;
      endcase
   end

   // An accepted flag-setting op overrides a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (accept && bus.in_setflags) begin
         flags_q <= bus.in_flags;
      end else if (flags_clr) begin
         flags_q <= 4'b0000;
      end
   end

`ifdef EXEC_SKID_BUFFER_EN
   logic        skid_valid;
   logic [15:0] skid_result;
   logic [2:0]  skid_dest;
   logic        skid_taken;

   assign bus.in_ready = ~skid_valid;

   // skid_valid implies out_valid, so a full skid only waits for the output to drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= 16'h0000;
         bus.out_dest   <= 3'b000;
         bus.out_taken  <= 1'b0;
         skid_valid     <= 1'b0;
         skid_result    <= 16'h0000;
         skid_dest      <= 3'b000;
         skid_taken     <= 1'b0;
      end else if (skid_valid) begin
         if (bus.out_ready) begin
            bus.out_result <= skid_result;
            bus.out_dest   <= skid_dest;
            bus.out_taken  <= skid_taken;
            skid_valid     <= 1'b0;
         end
      end else if (accept) begin
         if (!bus.out_valid || bus.out_ready) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= bus.in_result;
            bus.out_dest   <= bus.in_dest;
            bus.out_taken  <= in_taken;
         end else begin
            skid_valid     <= 1'b1;
            skid_result    <= bus.in_result;
            skid_dest      <= bus.in_dest;
            skid_taken     <= in_taken;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
`else
   assign bus.in_ready = ~bus.out_valid | bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= 16'h0000;
         bus.out_dest   <= 3'b000;
         bus.out_taken  <= 1'b0;
      end else if (accept) begin
         bus.out_valid  <= 1'b1;
         bus.out_result <= bus.in_result;
         bus.out_dest   <= bus.in_dest;
         bus.out_taken  <= in_taken;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_exec_writeback_stage.sv
// tb/tb_exec_writeback_stage.sv - directed bench for exec_writeback_stage (either EXEC_SKID_BUFFER_EN build)
module tb_exec_writeback_stage;

   logic       clk;
   logic       rst_n;
   logic       flags_clr;
   logic [3:0] flags_q;
   int         checks;
   int         errors;

   exec_writeback_stage_if bif ();

   exec_writeback_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flags_clr (flags_clr),
      .flags_q   (flags_q),
      .bus       (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f,
                        input logic sf, input logic [2:0] d, input logic [2:0] c);
      bif.in_valid    = v;
      bif.in_result   = r;
      bif.in_flags    = f;
      bif.in_setflags = sf;
      bif.in_dest     = d;
      bif.in_cond     = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] tbl_flags [8];
   logic [2:0] tbl_cond  [8];
   logic       tbl_taken [8];

   initial begin
      checks = 0;
      errors = 0;
      tbl_flags = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
      tbl_cond  = '{3'b011,  3'b100,  3'b100,  3'b101,  3'b101,  3'b110,  3'b111,  3'b000};
      tbl_taken = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};

      rst_n         = 1'b0;
      flags_clr     = 1'b0;
      bif.out_ready = 1'b0;
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 3'd0, 3'd0);
      #2;
      check("rst_out_valid", bif.out_valid, 16'd0);
      check("rst_out_result", bif.out_result, 16'h0000);
      check("rst_out_dest", bif.out_dest, 16'd0);
      check("rst_out_taken", bif.out_taken, 16'd0);
      check("rst_flags_q", flags_q, 16'd0);
      check("rst_in_ready", bif.in_ready, 16'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // First op, unconditional, no flag update
      bif.out_ready = 1'b1;
      drive(1'b1, 16'h1234, 4'b1111, 1'b0, 3'd5, 3'b000);
      tick();
      check("a_out_valid", bif.out_valid, 16'd1);
      check("a_out_result", bif.out_result, 16'h1234);
      check("a_out_dest", bif.out_dest, 16'd5);
      check("a_out_taken", bif.out_taken, 16'd1);
      check("a_flags_q", flags_q, 16'd0);

      drive(1'b1, 16'h0001, 4'b1000, 1'b1, 3'd1, 3'b001);
      tick();
      check("z_set_taken", bif.out_taken, 16'd1);
      check("z_set_flags", flags_q, 16'h8);
      check("z_set_result", bif.out_result, 16'h0001);

      drive(1'b1, 16'h0002, 4'b0111, 1'b0, 3'd2, 3'b010);
      tick();
      check("nz_taken", bif.out_taken, 16'd0);
      check("nz_flags_hold", flags_q, 16'h8);
      check("nz_dest", bif.out_dest, 16'd2);

      // Eight back-to-back ops covering the remaining condition codes
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'h0100 + 16'(i), tbl_flags[i], 1'b1, 3'(i), tbl_cond[i]);
         tick();
         check($sformatf("b2b%0d_valid", i), bif.out_valid, 16'd1);
         check($sformatf("b2b%0d_result", i), bif.out_result, 16'h0100 + 16'(i));
         check($sformatf("b2b%0d_dest", i), bif.out_dest, 16'(i));
         check($sformatf("b2b%0d_taken", i), bif.out_taken, 16'(tbl_taken[i]));
         check($sformatf("b2b%0d_flags", i), flags_q, 16'(tbl_flags[i]));
      end
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 3'd0, 3'd0);
      tick();
      check("drain_empty", bif.out_valid, 16'd0);

      // Stall: A, B, C offered with out_ready low
      bif.out_ready = 1'b0;
      drive(1'b1, 16'hA00A, 4'b0000, 1'b0, 3'd1, 3'b000);
      #1;
      check("stall_ready_empty", bif.in_ready, 16'd1);
      tick();
      check("stall_a_valid", bif.out_valid, 16'd1);
      check("stall_a_result", bif.out_result, 16'hA00A);
      drive(1'b1, 16'hB00B, 4'b0101, 1'b1, 3'd2, 3'b110);
`ifdef EXEC_SKID_BUFFER_EN
      #1;
      check("skid_ready_b", bif.in_ready, 16'd1);
      tick();
      check("skid_full_ready", bif.in_ready, 16'd0);
      check("skid_b_flags", flags_q, 16'h5);
      drive(1'b1, 16'hC00C, 4'b0000, 1'b0, 3'd3, 3'b001);
      tick();
      check("skid_hold_result", bif.out_result, 16'hA00A);
      check("skid_hold_dest", bif.out_dest, 16'd1);
      check("skid_c_blocked", bif.in_ready, 16'd0);
      bif.out_ready = 1'b1;
      tick();
      check("skid_b_result", bif.out_result, 16'hB00B);
      check("skid_b_taken", bif.out_taken, 16'd1);
      check("skid_ready_again", bif.in_ready, 16'd1);
      tick();
`else
      #1;
      check("ns_ready_stalled", bif.in_ready, 16'd0);
      tick();
      tick();
      check("ns_hold_result", bif.out_result, 16'hA00A);
      check("ns_hold_dest", bif.out_dest, 16'd1);
      check("ns_flags_unchanged", flags_q, 16'h0);
      bif.out_ready = 1'b1;
      #1;
      check("ns_ready_comb", bif.in_ready, 16'd1);
      tick();
      check("ns_b_result", bif.out_result, 16'hB00B);
      check("ns_b_taken", bif.out_taken, 16'd1);
      check("ns_b_flags", flags_q, 16'h5);
      drive(1'b1, 16'hC00C, 4'b0000, 1'b0, 3'd3, 3'b001);
      tick();
`endif
      check("stall_c_result", bif.out_result, 16'hC00C);
      check("stall_c_dest", bif.out_dest, 16'd3);
      check("stall_c_taken", bif.out_taken, 16'd0);
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 3'd0, 3'd0);
      tick();
      check("stall_drained", bif.out_valid, 16'd0);

      // Flag clear versus coincident flag-setting op, then clear alone
      flags_clr = 1'b1;
      drive(1'b1, 16'h0D0D, 4'b0110, 1'b1, 3'd4, 3'b000);
      tick();
      check("clr_set_wins", flags_q, 16'h6);
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 3'd0, 3'd0);
      tick();
      check("clr_alone", flags_q, 16'h0);
      flags_clr = 1'b0;

      // Async reset during a stall with buffered ops
      bif.out_ready = 1'b0;
      drive(1'b1, 16'h1111, 4'b1001, 1'b1, 3'd1, 3'b000);
      tick();
      drive(1'b1, 16'h2222, 4'b0000, 1'b0, 3'd2, 3'b000);
      tick();
      check("pre_rst_valid", bif.out_valid, 16'd1);
      check("pre_rst_flags", flags_q, 16'h9);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", bif.out_valid, 16'd0);
      check("async_rst_flags", flags_q, 16'h0);
      check("async_rst_result", bif.out_result, 16'h0000);
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bif.out_ready = 1'b1;
      drive(1'b1, 16'h5A5A, 4'b0000, 1'b0, 3'd6, 3'b000);
      #1;
      check("post_rst_ready", bif.in_ready, 16'd1);
      tick();
      check("post_rst_valid", bif.out_valid, 16'd1);
      check("post_rst_result", bif.out_result, 16'h5A5A);
      check("post_rst_dest", bif.out_dest, 16'd6);
      check("post_rst_taken", bif.out_taken, 16'd1);
      drive(1'b0, 16'h0000, 4'h0, 1'b0, 3'd0, 3'd0);
      tick();
      check("post_rst_drain", bif.out_valid, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
